// File: rtl/mem_arb_pkg.sv
// Types and constants for the fetch/data memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DATA
    } arb_owner_t;

    localparam logic [3:0]  STROBE_ALL = 4'b1111;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/riscv_types.sv
// Shared core types referenced by the memory-side blocks.
package riscv_types;

    typedef enum logic [1:0] {
        STORE_BYTE     = 2'b00,
        STORE_HALFWORD = 2'b01,
        STORE_WORD     = 2'b10
    } store_t;

endpackage

// File: rtl/byte_lane_gen.sv
// Byte strobes and lane-replicated write data for a store.
module byte_lane_gen
    import riscv_types::*;
    import mem_arb_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep
);

    // Reserved encoding 2'b11 falls through to a full-word store.
    always_comb begin
        sel       = STROBE_ALL;
        wdata_rep = wdata;
        case (store_type)
            STORE_BYTE: begin
                sel       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            STORE_HALFWORD: begin
                sel       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the data port:
// data has priority, fetch is protected by a starvation counter, stuck accesses time out.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_store_type,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned StarveW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TmoW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [TmoW-1:0]    TmoLast   = TmoW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    arb_owner_t         owner_q, owner_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]         bus_sel_q, bus_sel_d;
    logic               if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic               dm_ack_q, dm_ack_d, dm_err_q, dm_err_d;
    logic [31:0]        if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic [3:0]         lane_sel;
    logic [31:0]        lane_wdata;
    logic               grant_if;

    byte_lane_gen u_lanes (
        .store_type (dm_store_type),
        .addr_lo    (dm_addr[1:0]),
        .wdata      (dm_wdata),
        .sel        (lane_sel),
        .wdata_rep  (lane_wdata)
    );

    assign grant_if = if_req &&
                      (!dm_req || ((STARVE_LIMIT != 0) && (starve_q == StarveMax)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = if_req ? starve_q : '0;
        tmo_d       = tmo_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_err_d    = if_err_q;
        dm_err_d    = dm_err_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = BUSY;
                    owner_d     = OWN_IF;
                    starve_d    = '0;
                    tmo_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr & WORD_MASK;
                    bus_wdata_d = '0;
                    bus_sel_d   = STROBE_ALL;
                end else if (dm_req) begin
                    state_d     = BUSY;
                    owner_d     = OWN_DATA;
                    tmo_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_addr_d  = dm_addr & WORD_MASK;
                    bus_wdata_d = dm_we ? lane_wdata : '0;
                    bus_sel_d   = dm_we ? lane_sel : STROBE_ALL;
                    if (if_req && (starve_q != StarveMax)) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end
            end
            BUSY: begin
                if (bus_ack || ((TIMEOUT != 0) && (tmo_q == TmoLast))) begin
                    // A timeout returns zero data with the error flag raised.
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : '0;
                        if_err_d   = !bus_ack;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = bus_ack ? bus_rdata : '0;
                        dm_err_d   = !bus_ack;
                    end
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DATA;
            starve_q    <= '0;
            tmo_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus between the instruction-fetch port (IF1/IF2) and the data port (MEM stage) of the 5-stage core.
- Fixed data priority with a starvation guard for fetch.
- Routes read data and ack back to the owning requester.
- Generates byte strobes from store type and a bus timeout error.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while fetch is pending; 0 = pure data priority.
- TIMEOUT, 64: cycles in BUSY without bus_ack before abort; 0 = timeout disabled.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held with if_addr stable until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  one-cycle pulse, fetch response valid
- if_rdata  out  32  fetched instruction, valid with if_ack
- if_err  out  1  fetch timed out, valid with if_ack
- dm_req  in  1  data request, held with payload stable until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data, right-aligned
- dm_store_type  in  2  riscv_types::store_t
- dm_ack  out  1  one-cycle pulse, data response valid
- dm_rdata  out  32  load data (raw word), valid with dm_ack
- dm_err  out  1  data access timed out, valid with dm_ack
- bus_req  out  1  registered bus request, held until bus_ack
- bus_we  out  1  registered write enable
- bus_addr  out  32  registered address, {addr[31:2],2'b00}
- bus_wdata  out  32  registered lane-replicated write data
- bus_sel  out  4  registered byte strobes
- bus_ack  in  1  bus completion, sampled only in BUSY
- bus_rdata  in  32  valid with bus_ack

Behaviour:
- Reset: every output 0, state IDLE, owner DATA, starve_cnt 0, tmo_cnt 0.
- FSM IDLE: arbitrate at the clock edge and load the bus registers.
  - dm_req wins, unless if_req && starve_cnt==STARVE_LIMIT && STARVE_LIMIT!=0, in which case IF wins.
  - IF only pending: IF wins.
  - No request: stay in IDLE.
  - On any grant: go to BUSY, bus_req=1.
- FSM BUSY: bus outputs are held constant.
  - bus_ack=1: latch bus_rdata into the owner's rdata, err=0, go to RESP, bus_req=0.
  - tmo_cnt==TIMEOUT-1 (TIMEOUT!=0): rdata=0, err=1, go to RESP, bus_req=0.
  - Otherwise: tmo_cnt++.
- FSM RESP: owner's ack=1 for exactly this cycle; no arbitration; go to IDLE. Non-owner ack stays 0.
- Minimum latency: req sampled at edge t, bus_req high in cycle t+1.
  - bus_ack in t+1 gives ack in cycle t+2 and IDLE in t+3.
  - Back-to-back throughput is one access per 3 cycles.
- starve_cnt:
  - Increments on each data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on IF grant or any cycle with if_req=0.
- Strobes, for stores:
  - STORE_WORD: sel=1111.
  - STORE_HALFWORD: sel=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - STORE_BYTE: sel=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Encoding 2'b11: treated as word.
  - Misaligned halfwords are not checked here; upstream traps them.
- Strobes, for loads and fetch: sel=1111, we=0, wdata=0. Load extension happens in the MEM stage.
- tmo_cnt clears on every grant.
- bus_ack outside BUSY is ignored.
- Reset mid-transaction: next cycle bus_req=0, no ack/err issued, state IDLE. Requesters re-issue.
- Requests deasserted while in BUSY are a protocol violation; the transaction completes regardless.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t {IDLE, BUSY, RESP}
  - arb_owner_t {OWN_IF, OWN_DATA}
  - STROBE_ALL=4'b1111
- store_t is reused from riscv_types.
- Sub-module byte_lane_gen: combinational store_t + addr[1:0] + wdata -> sel + replicated wdata, used once.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, bus_ack in first BUSY cycle with rdata=0x00000013 -> bus_addr=0x100, sel=1111, if_ack pulse 2 cycles after request with if_rdata=0x13, dm_ack=0.
- Store byte: dm_store_type=STORE_BYTE, addr=0x203, wdata=0xAB -> bus_addr=0x200, sel=1000, bus_wdata=0xABABABAB, bus_we=1; halfword at 0x202 with 0x1234 -> sel=1100, wdata=0x12341234.
- Contention with STARVE_LIMIT=4: if_req and dm_req held continuously, bus_ack immediate -> grant order D,D,D,D,I,D,D,D,D,I; with STARVE_LIMIT=0 IF never granted while dm_req=1.
- Timeout with TIMEOUT=8: dm_req, bus_ack never asserted -> bus_req high 8 cycles then 0, dm_ack=1 with dm_err=1, dm_rdata=0, next request grantable 1 cycle later.
- Reset mid-operation: reset=1 during BUSY -> next cycle bus_req=0, no ack; a later stray bus_ack in IDLE produces no ack.
- Simultaneous first requests after reset: both high in the same cycle -> data granted first, IF granted in the IDLE following dm_ack.
